// File: rtl/i2c_txn_arbiter.sv
// Two-requester arbiter in front of a single-transaction I2C master.
// A winner is picked in IDLE while the master reports ready. Its request
// fields are captured and the master is enabled until it reports busy.
// The block then waits for ready to return. If either wait runs past
// TIMEOUT cycles, the transaction is aborted and flagged with err.
//
// Ports
//   clk, rst                 clock; asynchronous active-low reset
//   req0/1, addr0/1,
//   rw0/1, wdata0/1          requester transaction requests (level, held until gnt)
//   gnt0/1                   one-cycle grant pulse, fields captured
//   done0/1, err, rdata      completion pulse, timeout flag, read byte
//   busy                     high whenever not IDLE
//   m_enable, m_addr, m_rw,
//   m_wdata                  command to the i2c master
//   m_ready, m_rdata         status and read data from the i2c master
module i2c_txn_arbiter #(
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TW      = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [6:0] addr0,
  input  logic [6:0] addr1,
  input  logic       rw0,
  input  logic       rw1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       err,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       m_enable,
  output logic [6:0] m_addr,
  output logic       m_rw,
  output logic [7:0] m_wdata,
  input  logic       m_ready,
  input  logic [7:0] m_rdata
);

  localparam int unsigned AW = 7;
  localparam int unsigned DW = 8;
  localparam logic [TW-1:0] TO_CNT = TW'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_BUSY,
    S_DONE,
    S_ABORT
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] cnt, cnt_nxt;
  logic          last, last_nxt;    // requester served most recently
  logic          owner, owner_nxt;  // requester of the transaction in flight
  logic          win1, abort, finish;

  logic          gnt0_nxt, gnt1_nxt, done0_nxt, done1_nxt, err_nxt, busy_nxt;
  logic          m_enable_nxt, m_rw_nxt;
  logic [AW-1:0] m_addr_nxt;
  logic [DW-1:0] m_wdata_nxt, rdata_nxt;

  // Next-state and next-output logic
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    last_nxt     = last;
    owner_nxt    = owner;
    m_enable_nxt = m_enable;
    m_addr_nxt   = m_addr;
    m_rw_nxt     = m_rw;
    m_wdata_nxt  = m_wdata;
    rdata_nxt    = rdata;
    gnt0_nxt     = 1'b0;
    gnt1_nxt     = 1'b0;
    done0_nxt    = 1'b0;
    done1_nxt    = 1'b0;
    err_nxt      = 1'b0;
    win1         = 1'b0;
    abort        = 1'b0;
    finish       = 1'b0;

    unique case (state)
      S_IDLE: begin
        if ((req0 || req1) && m_ready) begin
          // On a tie the requester not served last wins
          win1         = req1 && (!req0 || !last);
          owner_nxt    = win1;
          last_nxt     = win1;
          gnt0_nxt     = !win1;
          gnt1_nxt     = win1;
          m_addr_nxt   = win1 ? addr1 : addr0;
          m_rw_nxt     = win1 ? rw1 : rw0;
          m_wdata_nxt  = win1 ? wdata1 : wdata0;
          m_enable_nxt = 1'b1;
          cnt_nxt      = '0;
          state_nxt    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        if (!m_ready) begin
          m_enable_nxt = 1'b0;
          cnt_nxt      = '0;
          state_nxt    = S_BUSY;
        end else if (cnt == TO_CNT) begin
          abort = 1'b1;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      S_BUSY: begin
        if (m_ready) begin
          if (m_rw) rdata_nxt = m_rdata;
          finish    = 1'b1;
          state_nxt = S_DONE;
        end else if (cnt == TO_CNT) begin
          abort = 1'b1;
        end else begin
          cnt_nxt = cnt + TW'(1);
        end
      end
      S_DONE, S_ABORT: state_nxt = S_IDLE;
      default:         state_nxt = S_IDLE;
    endcase

    // The exit condition is tested first above, so it beats a timeout on the same cycle
    if (abort) begin
      state_nxt    = S_ABORT;
      m_enable_nxt = 1'b0;
      rdata_nxt    = '0;
      err_nxt      = 1'b1;
      finish       = 1'b1;
    end
    if (finish) begin
      done0_nxt = !owner;
      done1_nxt = owner;
    end
    busy_nxt = (state_nxt != S_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      last     <= 1'b1;
      owner    <= 1'b0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      err      <= 1'b0;
      busy     <= 1'b0;
      rdata    <= '0;
      m_enable <= 1'b0;
      m_addr   <= '0;
      m_rw     <= 1'b0;
      m_wdata  <= '0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      last     <= last_nxt;
      owner    <= owner_nxt;
      gnt0     <= gnt0_nxt;
      gnt1     <= gnt1_nxt;
      done0    <= done0_nxt;
      done1    <= done1_nxt;
      err      <= err_nxt;
      busy     <= busy_nxt;
      rdata    <= rdata_nxt;
      m_enable <= m_enable_nxt;
      m_addr   <= m_addr_nxt;
      m_rw     <= m_rw_nxt;
      m_wdata  <= m_wdata_nxt;
    end
  end

endmodule

// File: doc/i2c_txn_arbiter.md
I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 1023, max cycles allowed in LAUNCH or in BUSY before abort.
REQ-002 Parameter TW, default 10, timeout counter width; TW SHALL satisfy 2^TW > TIMEOUT.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 resets).
REQ-005 req0 / req1  input  1 each  transaction request per requester, level, held until matching gnt.
REQ-006 addr0 / addr1  input  7 each  target I2C slave address.
REQ-007 rw0 / rw1  input  1 each  0 = write, 1 = read.
REQ-008 wdata0 / wdata1  input  8 each  write byte.
REQ-009 gnt0 / gnt1  output  1 each  one-cycle pulse, request fields captured.
REQ-010 done0 / done1  output  1 each  one-cycle pulse, transaction finished.
REQ-011 err  output  1  valid with done pulse; 1 = timeout abort.
REQ-012 rdata  output  8  read byte; valid with done pulse, held until next done.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 m_enable  output  1  to i2c_master enable.
REQ-015 m_addr  output  7  to i2c_master addr.
REQ-016 m_rw  output  1  to i2c_master rw.
REQ-017 m_wdata  output  8  to i2c_master data_in.
REQ-018 m_ready  input  1  from i2c_master ready (1 = idle).
REQ-019 m_rdata  input  8  from i2c_master data_out.

Function
REQ-020 States: IDLE, LAUNCH, BUSY, DONE, ABORT; all outputs registered.
REQ-021 IDLE: when (req0|req1) and m_ready=1, select winner, capture its addr/rw/wdata into m_addr/m_rw/m_wdata, pulse its gnt for one cycle, set m_enable=1, go LAUNCH.
REQ-022 IDLE with m_ready=0: no grant, remain IDLE regardless of requests.
REQ-023 Arbitration: single request wins; both requesting -> requester not served last wins; last-served pointer updates on each grant.
REQ-024 LAUNCH: hold m_enable=1; on m_ready=0 clear m_enable, go BUSY.
REQ-025 BUSY: m_enable=0; on m_ready=1 capture m_rdata into rdata if captured rw=1 (rdata unchanged for writes), go DONE.
REQ-026 DONE: pulse done of granted requester one cycle, err=0, go IDLE; earliest next grant is the cycle after DONE.
REQ-027 Timeout counter clears on entry to LAUNCH and BUSY, increments each cycle there; at count=TIMEOUT with exit condition unmet go ABORT.
REQ-028 ABORT: m_enable=0, pulse done of granted requester with err=1, rdata forced to 0x00, go IDLE.
REQ-029 Exit condition met in the same cycle the count reaches TIMEOUT: exit condition wins, no abort.
REQ-030 Request fields and req of either requester ignored outside IDLE; req still high in IDLE after done starts a new transaction.
REQ-031 err is 0 whenever no done pulse is asserted.
REQ-032 gnt0/gnt1 never both high; done0/done1 never both high.

Reset
REQ-033 rst=0 asynchronously forces IDLE, last-served pointer = requester 1 (requester 0 wins first tie), counter 0, all outputs 0 (m_enable, gnt*, done*, err, busy, m_addr, m_rw, m_wdata, rdata).
REQ-034 Reset mid-transaction drops m_enable immediately; no done pulse for the interrupted transaction; after release, block waits for m_ready=1 before next grant.

Verification
REQ-035 Write: req0, addr0=0x55, rw0=0, wdata0=0xAB, master model ready low 40 cycles -> gnt0, m_addr=0x55, m_wdata=0xAB, m_enable until ready falls, done0 with err=0.
REQ-036 Read: req1, addr1=0x55, rw1=1, model returns 0xAB -> done1, err=0, rdata=0xAB.
REQ-037 Contention: req0 and req1 asserted same cycle from reset, held -> grant order 0,1,0,1; each done precedes next gnt.
REQ-038 Timeout: model never lowers ready, TIMEOUT=15 -> done0 with err=1, rdata=0x00, exactly 16 cycles after LAUNCH entry; busy low next cycle.
REQ-039 Ready low in IDLE: req0 high, m_ready=0 for 20 cycles -> no gnt0 until ready=1.
REQ-040 Reset in BUSY: rst=0 for 2 cycles -> m_enable=0, busy=0, no done pulse; next req served normally.
